nx_indirect_mem_arbiter: RTL and testbench
==========================================

// Module: nx_indirect_mem_arbiter
// PURPOSE
//  Arbitrates one single-port RAM between the datapath (hw port) and the
//  indirect-access controller (sw port: sw_cs/sw_we/sw_add/sw_wdat in, grant/rdat out).
//  Sits directly downstream of the indirect-access controller and directly upstream of the memory macro.
//  Datapath has priority by default. The controller's yield/reset requests escalate the sw port to win.
//  Owns read-return routing and the sw read-data holding register.
// PARAMETERS
//  N_ADDR_BITS   10  memory address width
//  N_DATA_BITS   32  memory data width
//  RD_LATENCY    1   mem_rdat valid this many cycles after mem_cs read (>=1); indirect controller needs 1
//  SW_BURST      4   max consecutive sw grants while in SW_PRI before priority returns to hw (>=1)
// PORTS
//  clk        in   1    clock
//  rst        in   1    asynchronous reset, active-high
//  hw_cs      in   1    datapath access request
//  hw_we      in   1    datapath write (1) / read (0)
//  hw_add     in   N_ADDR_BITS  datapath address
//  hw_wdat    in   N_DATA_BITS  datapath write data
//  hw_stall   out  1    combinational; hw access not taken this cycle, hold and retry
//  hw_rvld    out  1    hw read data valid
//  hw_rdat    out  N_DATA_BITS  hw read data (mem_rdat when hw_rvld, else 0)
//  sw_cs      in   1    controller access request
//  sw_we      in   1    controller write
//  sw_add     in   N_ADDR_BITS  controller address
//  sw_wdat    in   N_DATA_BITS  controller write data
//  sw_yield   in   1    controller timer msb; sw is starving
//  sw_reset   in   1    controller reset/init sweep in progress; sw owns memory
//  sw_grant   out  1    combinational; sw access taken this cycle
//  sw_rdat    out  N_DATA_BITS  last sw read data, held until the next sw read returns
//  mem_cs/mem_we  out 1 each    memory strobes
//  mem_add    out  N_ADDR_BITS; mem_wdat out N_DATA_BITS; mem_rdat in N_DATA_BITS
//  stat_hw_stalls / stat_sw_waits  out 16 each  stall counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=HW_PRI, burst_cnt=0, tag pipe cleared, sw_rdat=0, hw_rvld=0, stats=0.
//   Combinational outputs follow their inputs.
//  Winner (combinational), evaluated in order:
//   1. sw_reset=1: sw wins if sw_cs=1. hw_stall=hw_cs even when sw_cs=0 (hw locked out).
//   2. state=SW_PRI and sw_cs=1: sw wins.
//   3. sw_cs=1 and sw_yield=1: sw wins.
//   4. hw_cs=1: hw wins.
//   5. sw_cs=1: sw wins.
//  sw_grant=sw wins. hw_stall=hw_cs & !hw wins. mem_* muxed from the winner.
//   mem_cs=0 with no winner; mem_add/mem_wdat then 0.
//  FSM states: HW_PRI and SW_PRI.
//   HW_PRI->SW_PRI when sw_cs and hw_cs are both asserted and sw won through rule 3; burst_cnt<=1.
//   In SW_PRI, each sw_grant increments burst_cnt.
//   SW_PRI->HW_PRI when sw_cs=0, or when a grant occurs with burst_cnt==SW_BURST; burst_cnt<=0.
//   A sw_reset assertion does not change state.
//  Read return: a tag pipe RD_LATENCY deep carries {vld,owner} for each granted read (mem_cs & !mem_we).
//   At pipe output, owner=hw: hw_rvld=1. owner=sw: sw_rdat<=mem_rdat, visible the cycle after return.
//   With RD_LATENCY=1, sw_rdat is valid in the controller's READ_DONE cycle.
//  Writes produce no return. Back-to-back reads of either owner are supported every cycle.
//  Collision: same-cycle hw and sw requests to the same address are arbitrated normally.
//   There is no forwarding; the loser sees the winner's write on retry.
//  Reset mid-operation: in-flight tags are discarded, so no hw_rvld and no sw_rdat update for them.
// CONFIGURATION
//  NX_MEM_ARB_STATS_EN defined:
//   stat_hw_stalls counts cycles with hw_stall=1.
//   stat_sw_waits counts cycles with sw_cs & !sw_grant.
//   Both are 16-bit, saturate at 16'hffff, and reset to 0.
//  NX_MEM_ARB_STATS_EN undefined: both ports are tied to 0 and no counter flops are built.
// TESTING
//  1. Idle, sw read of 0x12 with mem[0x12]=0xA5A5 and RD_LATENCY=1.
//     -> sw_grant cycle 0; sw_rdat=0xA5A5 from cycle 2, held.
//  2. hw_cs held every cycle, sw_cs with sw_yield=0.
//     -> sw_grant stays 0 and hw_stall 0.
//     Raise sw_yield -> sw_grant and hw_stall same cycle, state SW_PRI.
//     With SW_BURST=4 and sw_cs held: exactly 4 sw grants, then hw wins.
//  3. sw_reset=1 with sw_cs low on alternate cycles and hw_cs=1.
//     -> hw_stall=1 every cycle; mem_cs only on sw_cs cycles.
//  4. Alternating hw and sw reads each cycle, RD_LATENCY=3.
//     -> hw_rvld/hw_rdat and sw_rdat each carry only their own data, in order, 3 cycles later.
//  5. rst pulse with 2 reads in flight.
//     -> no hw_rvld, sw_rdat=0, state HW_PRI after release.
//  6. NX_MEM_ARB_STATS_EN defined, hw stalled 70000 cycles.
//     -> stat_hw_stalls=16'hffff. Undefined -> stays 0.

Source files
------------

// File: rtl/nx_indirect_mem_arbiter_if.sv
// Bundle between the datapath/indirect controller, the arbiter and the memory macro.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface nx_indirect_mem_arbiter_if #(
  parameter int unsigned N_ADDR_BITS = 10,
  parameter int unsigned N_DATA_BITS = 32
);
  localparam int unsigned STAT_W = 16;

  logic                   hw_cs;
  logic                   hw_we;
  logic [N_ADDR_BITS-1:0] hw_add;
  logic [N_DATA_BITS-1:0] hw_wdat;
  logic                   hw_stall;
  logic                   hw_rvld;
  logic [N_DATA_BITS-1:0] hw_rdat;

  logic                   sw_cs;
  logic                   sw_we;
  logic [N_ADDR_BITS-1:0] sw_add;
  logic [N_DATA_BITS-1:0] sw_wdat;
  logic                   sw_yield;
  logic                   sw_reset;
  logic                   sw_grant;
  logic [N_DATA_BITS-1:0] sw_rdat;

  logic                   mem_cs;
  logic                   mem_we;
  logic [N_ADDR_BITS-1:0] mem_add;
  logic [N_DATA_BITS-1:0] mem_wdat;
  logic [N_DATA_BITS-1:0] mem_rdat;

  logic [STAT_W-1:0]      stat_hw_stalls;
  logic [STAT_W-1:0]      stat_sw_waits;

  modport slave (
    input  hw_cs, hw_we, hw_add, hw_wdat,
    input  sw_cs, sw_we, sw_add, sw_wdat, sw_yield, sw_reset,
    input  mem_rdat,
    output hw_stall, hw_rvld, hw_rdat,
    output sw_grant, sw_rdat,
    output mem_cs, mem_we, mem_add, mem_wdat,
    output stat_hw_stalls, stat_sw_waits
  );

  modport master (
    output hw_cs, hw_we, hw_add, hw_wdat,
    output sw_cs, sw_we, sw_add, sw_wdat, sw_yield, sw_reset,
    output mem_rdat,
    input  hw_stall, hw_rvld, hw_rdat,
    input  sw_grant, sw_rdat,
    input  mem_cs, mem_we, mem_add, mem_wdat,
    input  stat_hw_stalls, stat_sw_waits
  );
endinterface

// File: rtl/nx_indirect_mem_arbiter.sv
// Single-port RAM arbiter between datapath (hw) and indirect controller (sw), with read-return routing.
// Optional stall counters are built when NX_MEM_ARB_STATS_EN is defined.
module nx_indirect_mem_arbiter #(
  parameter int unsigned N_ADDR_BITS = 10,
  parameter int unsigned N_DATA_BITS = 32,
  parameter int unsigned RD_LATENCY  = 1,
  parameter int unsigned SW_BURST    = 4
) (
  input logic                    clk,
  input logic                    rst,
  nx_indirect_mem_arbiter_if.slave bus
);
  localparam int unsigned CNT_W  = $clog2(SW_BURST + 1);
  localparam int unsigned STAT_W = 16;

  typedef enum logic {HW_PRI = 1'b0, SW_PRI = 1'b1} state_e;

  typedef struct packed {
    logic vld;
    logic sw;
  } tag_t;

  state_e           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             sw_win, hw_win, yield_win;
  logic             hw_stall_c;
  tag_t             tag_q [RD_LATENCY];
  tag_t             tag_out;
  logic             hw_rvld_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HW_PRI;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Priority flips to sw only when a yield beats a live hw request; sw_reset freezes it.
  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    if (!bus.sw_reset) begin
      case (state)
        HW_PRI: begin
          if (yield_win && bus.hw_cs) begin
            state_nxt     = SW_PRI;
            burst_cnt_nxt = CNT_W'(1);
          end
        end
        SW_PRI: begin
          if (!bus.sw_cs) begin
            state_nxt     = HW_PRI;
            burst_cnt_nxt = '0;
          end else if (sw_win) begin
            if (burst_cnt >= CNT_W'(SW_BURST - 1)) begin
              state_nxt     = HW_PRI;
              burst_cnt_nxt = '0;
            end else begin
              burst_cnt_nxt = burst_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          state_nxt     = HW_PRI;
          burst_cnt_nxt = '0;
        end
      endcase
    end
  end

  // Winner selection and memory strobe mux.
  always_comb begin
    sw_win       = 1'b0;
    hw_win       = 1'b0;
    yield_win    = 1'b0;
    bus.mem_cs   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_add  = '0;
    bus.mem_wdat = '0;
    if (bus.sw_reset) begin
      sw_win = bus.sw_cs;
    end else if (state == SW_PRI && bus.sw_cs) begin
      sw_win = 1'b1;
    end else if (bus.sw_cs && bus.sw_yield) begin
      sw_win    = 1'b1;
      yield_win = 1'b1;
    end else if (bus.hw_cs) begin
      hw_win = 1'b1;
    end else if (bus.sw_cs) begin
      sw_win = 1'b1;
    end
    if (sw_win) begin
      bus.mem_cs   = 1'b1;
      bus.mem_we   = bus.sw_we;
      bus.mem_add  = bus.sw_add;
      bus.mem_wdat = bus.sw_wdat;
    end else if (hw_win) begin
      bus.mem_cs   = 1'b1;
      bus.mem_we   = bus.hw_we;
      bus.mem_add  = bus.hw_add;
      bus.mem_wdat = bus.hw_wdat;
    end
    hw_stall_c   = bus.hw_cs & ~hw_win;
    bus.hw_stall = hw_stall_c;
    bus.sw_grant = sw_win;
  end

  // Read tags travel alongside the memory latency so returns reach their owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0].vld <= (sw_win | hw_win) & ~bus.mem_we;
      tag_q[0].sw  <= sw_win;
      for (int unsigned i = 1; i < RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out     = tag_q[RD_LATENCY-1];
  assign hw_rvld_int = tag_out.vld & ~tag_out.sw;
  assign bus.hw_rvld = hw_rvld_int;
  assign bus.hw_rdat = hw_rvld_int ? bus.mem_rdat : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.sw_rdat <= '0;
    end else if (tag_out.vld && tag_out.sw) begin
      bus.sw_rdat <= bus.mem_rdat;
    end
  end

`ifdef NX_MEM_ARB_STATS_EN
  logic [STAT_W-1:0] hw_stalls_q, sw_waits_q;

  // Saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hw_stalls_q <= '0;
      sw_waits_q  <= '0;
    end else begin
      if (hw_stall_c && hw_stalls_q != '1) hw_stalls_q <= hw_stalls_q + STAT_W'(1);
      if (bus.sw_cs && !sw_win && sw_waits_q != '1) sw_waits_q <= sw_waits_q + STAT_W'(1);
    end
  end

  assign bus.stat_hw_stalls = hw_stalls_q;
  assign bus.stat_sw_waits  = sw_waits_q;
`else
  assign bus.stat_hw_stalls = '0;
  assign bus.stat_sw_waits  = '0;
`endif

endmodule

// File: tb/tb_nx_indirect_mem_arbiter.sv
// Directed bench: instance A (RD_LATENCY=1) and instance B (RD_LATENCY=3) with behavioural RAMs.
module tb_nx_indirect_mem_arbiter;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  nx_indirect_mem_arbiter_if #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW)) ba ();
  nx_indirect_mem_arbiter_if #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW)) bb ();

  nx_indirect_mem_arbiter #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW), .RD_LATENCY(1), .SW_BURST(4))
    dut_a (.clk(clk), .rst(rst), .bus(ba));
  nx_indirect_mem_arbiter #(.N_ADDR_BITS(AW), .N_DATA_BITS(DW), .RD_LATENCY(3), .SW_BURST(4))
    dut_b (.clk(clk), .rst(rst), .bus(bb));

  // Behavioural RAMs: A returns reads after 1 cycle, B after 3.
  logic [DW-1:0] mem_a [1024];
  logic [DW-1:0] mem_b [1024];
  logic [DW-1:0] rdq_a;
  logic [DW-1:0] rdq_b [3];

  always @(posedge clk) begin
    if (ba.mem_cs && ba.mem_we) mem_a[ba.mem_add] <= ba.mem_wdat;
    rdq_a <= (ba.mem_cs && !ba.mem_we) ? mem_a[ba.mem_add] : 32'hDEAD_BEEF;
    if (bb.mem_cs && bb.mem_we) mem_b[bb.mem_add] <= bb.mem_wdat;
    rdq_b[0] <= (bb.mem_cs && !bb.mem_we) ? mem_b[bb.mem_add] : 32'hDEAD_BEEF;
    rdq_b[1] <= rdq_b[0];
    rdq_b[2] <= rdq_b[1];
  end
  assign ba.mem_rdat = rdq_a;
  assign bb.mem_rdat = rdq_b[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ba.hw_cs = 1'b0; ba.hw_we = 1'b0; ba.hw_add = '0; ba.hw_wdat = '0;
    ba.sw_cs = 1'b0; ba.sw_we = 1'b0; ba.sw_add = '0; ba.sw_wdat = '0;
    ba.sw_yield = 1'b0; ba.sw_reset = 1'b0;
  endtask

  task automatic idle_b();
    bb.hw_cs = 1'b0; bb.hw_we = 1'b0; bb.hw_add = '0; bb.hw_wdat = '0;
    bb.sw_cs = 1'b0; bb.sw_we = 1'b0; bb.sw_add = '0; bb.sw_wdat = '0;
    bb.sw_yield = 1'b0; bb.sw_reset = 1'b0;
  endtask

  task automatic hw_write_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
    ba.hw_cs = 1'b1; ba.hw_we = 1'b1; ba.hw_add = a; ba.hw_wdat = d;
    tick();
    ba.hw_cs = 1'b0; ba.hw_we = 1'b0;
  endtask

  task automatic hw_write_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bb.hw_cs = 1'b1; bb.hw_we = 1'b1; bb.hw_add = a; bb.hw_wdat = d;
    tick();
    bb.hw_cs = 1'b0; bb.hw_we = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_a(); idle_b();
    tick(); tick();
    n_checks++; if (ba.sw_rdat !== 32'h0) begin n_fail++; $display("FAIL reset_sw_rdat: got %h want 0", ba.sw_rdat); end
    n_checks++; if (ba.hw_rvld !== 1'b0) begin n_fail++; $display("FAIL reset_hw_rvld: got %b want 0", ba.hw_rvld); end
    n_checks++; if (ba.mem_cs !== 1'b0 || ba.mem_add !== 10'h0 || ba.mem_wdat !== 32'h0) begin
      n_fail++; $display("FAIL reset_idle_mem: cs=%b add=%h wdat=%h want 0/0/0", ba.mem_cs, ba.mem_add, ba.mem_wdat); end
    n_checks++; if (ba.stat_hw_stalls !== 16'h0 || ba.stat_sw_waits !== 16'h0) begin
      n_fail++; $display("FAIL reset_stats: got %h/%h want 0/0", ba.stat_hw_stalls, ba.stat_sw_waits); end
    n_checks++; if (bb.sw_rdat !== 32'h0 || bb.hw_rvld !== 1'b0) begin
      n_fail++; $display("FAIL reset_b_outputs: sw_rdat=%h hw_rvld=%b want 0/0", bb.sw_rdat, bb.hw_rvld); end
    rst = 1'b0;
  endtask

  task automatic test_sw_read();
    hw_write_a(10'h12, 32'h0000_A5A5);
    hw_write_a(10'h34, 32'h5A5A_0001);
    ba.sw_cs = 1'b1; ba.sw_we = 1'b0; ba.sw_add = 10'h12;
    #1;
    n_checks++; if (ba.sw_grant !== 1'b1 || ba.hw_stall !== 1'b0) begin
      n_fail++; $display("FAIL sw_read_grant: grant=%b stall=%b want 1/0", ba.sw_grant, ba.hw_stall); end
    n_checks++; if (ba.mem_cs !== 1'b1 || ba.mem_we !== 1'b0 || ba.mem_add !== 10'h12) begin
      n_fail++; $display("FAIL sw_read_mem: cs=%b we=%b add=%h want 1/0/012", ba.mem_cs, ba.mem_we, ba.mem_add); end
    tick();
    ba.sw_cs = 1'b0;
    n_checks++; if (ba.sw_rdat !== 32'h0 || ba.hw_rvld !== 1'b0) begin
      n_fail++; $display("FAIL sw_read_cycle1: sw_rdat=%h hw_rvld=%b want 0/0", ba.sw_rdat, ba.hw_rvld); end
    tick();
    n_checks++; if (ba.sw_rdat !== 32'h0000_A5A5) begin n_fail++; $display("FAIL sw_read_cycle2: got %h want 0000a5a5", ba.sw_rdat); end
    tick(); tick();
    n_checks++; if (ba.sw_rdat !== 32'h0000_A5A5) begin n_fail++; $display("FAIL sw_read_held: got %h want 0000a5a5", ba.sw_rdat); end
  endtask

  task automatic test_hw_read();
    ba.hw_cs = 1'b1; ba.hw_we = 1'b0; ba.hw_add = 10'h34;
    #1;
    n_checks++; if (ba.hw_stall !== 1'b0 || ba.mem_cs !== 1'b1 || ba.sw_grant !== 1'b0) begin
      n_fail++; $display("FAIL hw_read_issue: stall=%b cs=%b grant=%b want 0/1/0", ba.hw_stall, ba.mem_cs, ba.sw_grant); end
    tick();
    ba.hw_cs = 1'b0;
    #1;
    n_checks++; if (ba.hw_rvld !== 1'b1 || ba.hw_rdat !== 32'h5A5A_0001) begin
      n_fail++; $display("FAIL hw_read_return: rvld=%b rdat=%h want 1/5a5a0001", ba.hw_rvld, ba.hw_rdat); end
    tick();
    n_checks++; if (ba.hw_rvld !== 1'b0 || ba.hw_rdat !== 32'h0 || ba.sw_rdat !== 32'h0000_A5A5) begin
      n_fail++; $display("FAIL hw_read_after: rvld=%b rdat=%h sw_rdat=%h want 0/0/0000a5a5", ba.hw_rvld, ba.hw_rdat, ba.sw_rdat); end
  endtask

  task automatic test_yield_burst();
    logic exp;
    ba.hw_cs = 1'b1; ba.hw_we = 1'b1; ba.hw_add = 10'h100; ba.hw_wdat = 32'h11;
    ba.sw_cs = 1'b1; ba.sw_we = 1'b1; ba.sw_add = 10'h200; ba.sw_wdat = 32'h22;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (ba.sw_grant !== 1'b0 || ba.hw_stall !== 1'b0 || ba.mem_add !== 10'h100) begin
        n_fail++; $display("FAIL no_yield_%0d: grant=%b stall=%b add=%h want 0/0/100", i, ba.sw_grant, ba.hw_stall, ba.mem_add); end
      tick();
    end
    ba.sw_yield = 1'b1;
    #1;
    n_checks++; if (ba.sw_grant !== 1'b1 || ba.hw_stall !== 1'b1 || ba.mem_wdat !== 32'h22) begin
      n_fail++; $display("FAIL yield_win: grant=%b stall=%b wdat=%h want 1/1/22", ba.sw_grant, ba.hw_stall, ba.mem_wdat); end
    tick();
    ba.sw_yield = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp = (i < 3);
      #1;
      n_checks++; if (ba.sw_grant !== exp || ba.hw_stall !== exp) begin
        n_fail++; $display("FAIL burst_%0d: grant=%b stall=%b want %b/%b", i, ba.sw_grant, ba.hw_stall, exp, exp); end
      tick();
    end
    // Re-enter sw priority, then leave it by dropping sw_cs.
    ba.sw_yield = 1'b1;
    tick();
    ba.sw_yield = 1'b0; ba.sw_cs = 1'b0;
    tick();
    ba.sw_cs = 1'b1;
    #1;
    n_checks++; if (ba.sw_grant !== 1'b0 || ba.hw_stall !== 1'b0) begin
      n_fail++; $display("FAIL sw_drop_exit: grant=%b stall=%b want 0/0", ba.sw_grant, ba.hw_stall); end
    idle_a();
    tick();
  endtask

  task automatic test_sw_reset();
    logic cs;
    ba.hw_cs = 1'b1; ba.hw_we = 1'b1; ba.hw_add = 10'h300; ba.hw_wdat = 32'h1;
    ba.sw_reset = 1'b1; ba.sw_we = 1'b1; ba.sw_add = 10'h301; ba.sw_wdat = 32'h2;
    for (int i = 0; i < 6; i++) begin
      cs = (i % 2 == 0);
      ba.sw_cs = cs;
      #1;
      n_checks++; if (ba.hw_stall !== 1'b1 || ba.mem_cs !== cs || ba.sw_grant !== cs) begin
        n_fail++; $display("FAIL sw_reset_%0d: stall=%b mem_cs=%b grant=%b want 1/%b/%b", i, ba.hw_stall, ba.mem_cs, ba.sw_grant, cs, cs); end
      tick();
    end
    ba.sw_reset = 1'b0; ba.sw_cs = 1'b1; ba.sw_add = 10'h300;
    #1;
    n_checks++; if (ba.sw_grant !== 1'b0 || ba.mem_wdat !== 32'h1 || ba.mem_add !== 10'h300) begin
      n_fail++; $display("FAIL collision_hw_wins: grant=%b wdat=%h add=%h want 0/1/300", ba.sw_grant, ba.mem_wdat, ba.mem_add); end
    idle_a();
    tick();
  endtask

  task automatic test_alternating();
    logic [DW-1:0] exp_sw;
    logic          exp_vld;
    logic [DW-1:0] exp_rdat;
    for (int k = 0; k < 4; k++) begin
      hw_write_b(AW'(10'h40 + k), DW'(32'h1000 + k));
      hw_write_b(AW'(10'h50 + k), DW'(32'h2000 + k));
    end
    exp_sw = 32'h0;
    for (int c = 0; c < 12; c++) begin
      idle_b();
      if (c < 8) begin
        if (c % 2 == 0) begin
          bb.hw_cs = 1'b1; bb.hw_add = AW'(10'h40 + c / 2);
        end else begin
          bb.sw_cs = 1'b1; bb.sw_add = AW'(10'h50 + c / 2);
        end
      end
      exp_vld  = (c >= 3) && ((c - 3) % 2 == 0) && (c - 3 < 8);
      exp_rdat = exp_vld ? DW'(32'h1000 + (c - 3) / 2) : 32'h0;
      if (c >= 5 && ((c - 4) % 2 == 1)) exp_sw = DW'(32'h2000 + (c - 5) / 2);
      #1;
      n_checks++; if (bb.hw_rvld !== exp_vld || bb.hw_rdat !== exp_rdat) begin
        n_fail++; $display("FAIL alt_hw_c%0d: rvld=%b rdat=%h want %b/%h", c, bb.hw_rvld, bb.hw_rdat, exp_vld, exp_rdat); end
      n_checks++; if (bb.sw_rdat !== exp_sw) begin
        n_fail++; $display("FAIL alt_sw_c%0d: got %h want %h", c, bb.sw_rdat, exp_sw); end
      tick();
    end
    idle_b();
  endtask

  task automatic test_reset_inflight();
    // A: hw writes while sw yields in with reads; B: one hw and one sw read in flight.
    ba.hw_cs = 1'b1; ba.hw_we = 1'b1; ba.hw_add = 10'h3FF; ba.hw_wdat = 32'h7;
    ba.sw_cs = 1'b1; ba.sw_we = 1'b0; ba.sw_add = 10'h34; ba.sw_yield = 1'b1;
    bb.hw_cs = 1'b1; bb.hw_we = 1'b0; bb.hw_add = 10'h41;
    tick();
    ba.sw_yield = 1'b0;
    bb.hw_cs = 1'b0; bb.sw_cs = 1'b1; bb.sw_we = 1'b0; bb.sw_add = 10'h51;
    tick();
    idle_b();
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (ba.sw_grant !== 1'b0 || ba.hw_stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_state_hw_pri: grant=%b stall=%b want 0/0", ba.sw_grant, ba.hw_stall); end
    idle_a();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_checks++; if (bb.hw_rvld !== 1'b0 || bb.sw_rdat !== 32'h0 || ba.sw_rdat !== 32'h0) begin
        n_fail++; $display("FAIL rst_inflight_c%0d: b_rvld=%b b_sw_rdat=%h a_sw_rdat=%h want 0/0/0", c, bb.hw_rvld, bb.sw_rdat, ba.sw_rdat); end
      tick();
    end
  endtask

  task automatic test_stats();
    idle_a();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ba.hw_cs = 1'b1; ba.hw_we = 1'b1; ba.hw_add = 10'h3FE;
    ba.sw_cs = 1'b1; ba.sw_we = 1'b1; ba.sw_add = 10'h3FD;
    repeat (3) tick();
    ba.sw_cs = 1'b0; ba.sw_reset = 1'b1;
    repeat (5) tick();
`ifdef NX_MEM_ARB_STATS_EN
    n_checks++; if (ba.stat_hw_stalls !== 16'd5 || ba.stat_sw_waits !== 16'd3) begin
      n_fail++; $display("FAIL stats_count: stalls=%0d waits=%0d want 5/3", ba.stat_hw_stalls, ba.stat_sw_waits); end
    repeat (69995) tick();
    n_checks++; if (ba.stat_hw_stalls !== 16'hFFFF || ba.stat_sw_waits !== 16'd3) begin
      n_fail++; $display("FAIL stats_saturate: stalls=%h waits=%h want ffff/0003", ba.stat_hw_stalls, ba.stat_sw_waits); end
`else
    repeat (20) tick();
    n_checks++; if (ba.stat_hw_stalls !== 16'h0 || ba.stat_sw_waits !== 16'h0) begin
      n_fail++; $display("FAIL stats_disabled: stalls=%h waits=%h want 0/0", ba.stat_hw_stalls, ba.stat_sw_waits); end
`endif
    idle_a();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_a();
    idle_b();
    test_reset();
    test_sw_read();
    test_hw_read();
    test_yield_burst();
    test_sw_reset();
    test_alternating();
    test_reset_inflight();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
